// File: rtl/dram_pkg.sv
// Shared encodings for the DRAM port arbiter: sequencer select codes,
// arbiter states and default refresh interval.
package dram_pkg;

    localparam int unsigned REFRESH_CNT_DEF = 374;
    localparam int unsigned CNT_W_DEF       = 12;
    localparam int unsigned SEL_W           = 2;
    localparam int unsigned PEND_W          = 2;

    localparam logic [SEL_W-1:0] SEL_CPU = 2'b00;
    localparam logic [SEL_W-1:0] SEL_DMA = 2'b01;
    localparam logic [SEL_W-1:0] SEL_REF = 2'b10;

    localparam logic [1:0] DSACK_32   = 2'b11;
    localparam logic [1:0] DSACK_NONE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_CPU_HOLD = 2'd2,
        ST_RECOVER  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter with a saturating backlog of
// pending CAS-before-RAS refreshes and a sticky overflow flag.
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int unsigned REFRESH_CNT = REFRESH_CNT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              refresh_done,
    output logic [PEND_W-1:0] ref_pending,
    output logic              refresh_ovf
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              tick;

    always_comb begin
        tick   = (cnt_q == CNT_W'(REFRESH_CNT - 1));
        cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
        pend_d = pend_q;
        ovf_d  = ovf_q;
        // A tick and a completed refresh in the same cycle cancel out.
        if (tick && !refresh_done) begin
            if (pend_q == PEND_W'(3)) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (!tick && refresh_done && (pend_q != '0)) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q  <= '0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ref_pending = pend_q;
    assign refresh_ovf = ovf_q;

endmodule

// File: rtl/dram_port_arb.sv
// Shares the DRAM sequencer between 68030 bus cycles, the DMA port and
// refresh; owns requester priority and 68030 DSACK termination.
module dram_port_arb
    import dram_pkg::*;
#(
    parameter int unsigned REFRESH_CNT = REFRESH_CNT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             nAS,
    input  logic             nRAMSEL,
    input  logic             RnW,
    input  logic             dma_req,
    input  logic             dma_wr,
    output logic             dma_ack,
    output logic             seq_start,
    output logic [SEL_W-1:0] seq_sel,
    output logic             seq_wr,
    input  logic             seq_done,
    output logic [1:0]       DSACK,
    output logic             refresh_ovf
);

    arb_state_e        state_q, state_d;
    logic              as_s1_q, as_s1_d, as_s2_q, as_s2_d;
    logic              sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
    logic              last_dma_q, last_dma_d;
    logic              dma_ack_q, dma_ack_d;
    logic              seq_start_q, seq_start_d;
    logic [SEL_W-1:0]  seq_sel_q, seq_sel_d;
    logic              seq_wr_q, seq_wr_d;
    logic [1:0]        dsack_q, dsack_d;
    logic [PEND_W-1:0] ref_pending;
    logic              cpu_req_c;
    logic              refresh_done_c;

    assign cpu_req_c      = as_s2_q & sel_s2_q;
    assign refresh_done_c = (state_q == ST_BUSY) && seq_done && (seq_sel_q == SEL_REF);

    dram_refresh_timer #(
        .REFRESH_CNT (REFRESH_CNT),
        .CNT_W       (CNT_W)
    ) u_refresh_timer (
        .CLK          (CLK),
        .nRST         (nRST),
        .refresh_done (refresh_done_c),
        .ref_pending  (ref_pending),
        .refresh_ovf  (refresh_ovf)
    );

    always_comb begin
        as_s1_d     = ~nAS;
        as_s2_d     = as_s1_q;
        sel_s1_d    = ~nRAMSEL;
        sel_s2_d    = sel_s1_q;
        state_d     = state_q;
        last_dma_d  = last_dma_q;
        dma_ack_d   = 1'b0;
        seq_start_d = 1'b0;
        seq_sel_d   = seq_sel_q;
        seq_wr_d    = seq_wr_q;
        dsack_d     = dsack_q;
        case (state_q)
            ST_IDLE: begin
                // Refresh first, then round-robin between CPU and DMA.
                if (ref_pending != '0) begin
                    seq_sel_d   = SEL_REF;
                    seq_wr_d    = 1'b0;
                    seq_start_d = 1'b1;
                    state_d     = ST_BUSY;
                end else if (cpu_req_c && (!dma_req || last_dma_q)) begin
                    seq_sel_d   = SEL_CPU;
                    seq_wr_d    = ~RnW;
                    seq_start_d = 1'b1;
                    last_dma_d  = 1'b0;
                    state_d     = ST_BUSY;
                end else if (dma_req) begin
                    seq_sel_d   = SEL_DMA;
                    seq_wr_d    = dma_wr;
                    seq_start_d = 1'b1;
                    last_dma_d  = 1'b1;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (seq_done) begin
                    if (seq_sel_q == SEL_REF) begin
                        state_d = ST_IDLE;
                    end else if (seq_sel_q == SEL_DMA) begin
                        dma_ack_d = 1'b1;
                        state_d   = ST_RECOVER;
                    end else if (as_s2_q) begin
                        dsack_d = DSACK_32;
                        state_d = ST_CPU_HOLD;
                    end else begin
                        // CPU abandoned the cycle: finish silently.
                        dsack_d = DSACK_NONE;
                        state_d = ST_RECOVER;
                    end
                end
            end
            ST_CPU_HOLD: begin
                if (!as_s2_q) begin
                    dsack_d = DSACK_NONE;
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_IDLE;
            as_s1_q     <= 1'b0;
            as_s2_q     <= 1'b0;
            sel_s1_q    <= 1'b0;
            sel_s2_q    <= 1'b0;
            last_dma_q  <= 1'b0;
            dma_ack_q   <= 1'b0;
            seq_start_q <= 1'b0;
            seq_sel_q   <= SEL_CPU;
            seq_wr_q    <= 1'b0;
            dsack_q     <= DSACK_NONE;
        end else begin
            state_q     <= state_d;
            as_s1_q     <= as_s1_d;
            as_s2_q     <= as_s2_d;
            sel_s1_q    <= sel_s1_d;
            sel_s2_q    <= sel_s2_d;
            last_dma_q  <= last_dma_d;
            dma_ack_q   <= dma_ack_d;
            seq_start_q <= seq_start_d;
            seq_sel_q   <= seq_sel_d;
            seq_wr_q    <= seq_wr_d;
            dsack_q     <= dsack_d;
        end
    end

    assign dma_ack   = dma_ack_q;
    assign seq_start = seq_start_q;
    assign seq_sel   = seq_sel_q;
    assign seq_wr    = seq_wr_q;
    assign DSACK     = dsack_q;

endmodule

// File: tb/tb_dram_port_arb.sv
// Scoreboard bench for dram_port_arb: expected grants are queued as requests
// are raised and checked as seq_start pulses appear; a small sequencer model answers.
module tb_dram_port_arb;
    import dram_pkg::*;

    localparam int unsigned RCNT = 1000;

    typedef struct packed {
        logic [1:0] sel;
        logic       wr;
    } exp_t;

    logic       CLK, nRST, nAS, nRAMSEL, RnW, dma_req, dma_wr, seq_done;
    logic       dma_ack, seq_start, seq_wr, refresh_ovf;
    logic [1:0] seq_sel, DSACK;

    dram_port_arb #(.REFRESH_CNT(RCNT), .CNT_W(12)) u_dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .nAS         (nAS),
        .nRAMSEL     (nRAMSEL),
        .RnW         (RnW),
        .dma_req     (dma_req),
        .dma_wr      (dma_wr),
        .dma_ack     (dma_ack),
        .seq_start   (seq_start),
        .seq_sel     (seq_sel),
        .seq_wr      (seq_wr),
        .seq_done    (seq_done),
        .DSACK       (DSACK),
        .refresh_ovf (refresh_ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   total, bad, cyc, grants, acks, start_cyc, busy_cnt, done_dly, nas_gap;
    bit   hold_done, in_op, cpu_auto, cpu_rearm, dma_drop;
    logic [1:0] cur_sel;
    logic       cur_wr;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_grant(input logic [1:0] sel, input logic wr);
        exp_q.push_back(exp_t'{sel: sel, wr: wr});
    endtask

    // One clock: sample outputs after the edge, play the sequencer and the requesters.
    task automatic step();
        exp_t e;
        @(posedge CLK);
        #1;
        cyc++;
        seq_done = 1'b0;
        if (seq_start === 1'b1) begin
            start_cyc = cyc;
            grants++;
            cur_sel   = seq_sel;
            cur_wr    = seq_wr;
            in_op     = 1'b1;
            busy_cnt  = done_dly;
            if (exp_q.size() == 0) begin
                chk("spurious_grant", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("grant_sel", 32'(seq_sel), 32'(e.sel));
                chk("grant_wr", 32'(seq_wr), 32'(e.wr));
            end
        end else if (in_op) begin
            chk("sel_stable", 32'({seq_sel, seq_wr}), 32'({cur_sel, cur_wr}));
            if (!hold_done) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    seq_done = 1'b1;
                    in_op    = 1'b0;
                end
            end
        end
        if (DSACK !== 2'b00) chk("dsack_owner", 32'(cur_sel), 32'(SEL_CPU));
        if (dma_ack === 1'b1) begin
            acks++;
            chk("ack_owner", 32'(cur_sel), 32'(SEL_DMA));
            if (dma_drop) dma_req = 1'b0;
        end
        if (cpu_auto && DSACK === 2'b11 && nAS == 1'b0) begin
            nAS     = 1'b1;
            nRAMSEL = 1'b1;
            nas_gap = 2;
        end else if (nas_gap > 0) begin
            nas_gap--;
            if (nas_gap == 0 && cpu_rearm) begin
                nAS     = 1'b0;
                nRAMSEL = 1'b0;
            end
        end
    endtask

    // Asserts nRST between edges and checks outputs clear without a clock.
    task automatic do_reset();
        nRST = 1'b0;
        #2;
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_seq_start", 32'(seq_start), 32'd0);
        chk("rst_seq_sel", 32'(seq_sel), 32'd0);
        chk("rst_seq_wr", 32'(seq_wr), 32'd0);
        chk("rst_dsack", 32'(DSACK), 32'd0);
        chk("rst_ovf", 32'(refresh_ovf), 32'd0);
        chk("rst_q_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        nAS = 1'b1; nRAMSEL = 1'b1; RnW = 1'b1;
        dma_req = 1'b0; dma_wr = 1'b0; seq_done = 1'b0;
        hold_done = 1'b0; in_op = 1'b0; cpu_auto = 1'b0; cpu_rearm = 1'b0;
        dma_drop = 1'b1; busy_cnt = 0; done_dly = 5; nas_gap = 0;
        grants = 0; acks = 0; start_cyc = 0; cur_sel = SEL_CPU; cur_wr = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        cyc  = 0;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        nRST = 1'b0; nAS = 1'b1; nRAMSEL = 1'b1; RnW = 1'b1;
        dma_req = 1'b0; dma_wr = 1'b0; seq_done = 1'b0;
        @(posedge CLK);
        #1;

        // Single CPU read: grant 3 cycles after nAS, DSACK after seq_done.
        do_reset();
        nAS = 1'b0; nRAMSEL = 1'b0; RnW = 1'b1;
        expect_grant(SEL_CPU, 1'b0);
        for (int i = 0; i < 20 && grants == 0; i++) step();
        chk("cpu_start_cyc", 32'(start_cyc), 32'd3);
        while (cyc < 8) step();
        chk("cpu_dsack_pre", 32'(DSACK), 32'd0);
        step();
        chk("cpu_dsack_on", 32'(DSACK), 32'd3);
        repeat (3) step();
        chk("cpu_dsack_hold", 32'(DSACK), 32'd3);
        nAS = 1'b1; nRAMSEL = 1'b1;
        repeat (2) step();
        chk("cpu_dsack_tail", 32'(DSACK), 32'd3);
        step();
        chk("cpu_dsack_off", 32'(DSACK), 32'd0);
        repeat (10) step();

        // DMA write: one ack pulse, no DSACK.
        do_reset();
        dma_wr = 1'b1; dma_req = 1'b1;
        expect_grant(SEL_DMA, 1'b1);
        for (int i = 0; i < 40 && acks == 0; i++) step();
        chk("dma_ack_seen", 32'(acks), 32'd1);
        chk("dma_ack_cyc", 32'(cyc), 32'd7);
        step();
        chk("dma_ack_pulse", 32'(dma_ack), 32'd0);
        repeat (10) step();
        chk("dma_dsack", 32'(DSACK), 32'd0);

        // Round robin with CPU and DMA both requesting: DMA first.
        do_reset();
        nAS = 1'b0; nRAMSEL = 1'b0; RnW = 1'b0;
        dma_wr = 1'b0; dma_req = 1'b1;
        cpu_auto = 1'b1; cpu_rearm = 1'b1; dma_drop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) expect_grant(SEL_DMA, 1'b0);
            else            expect_grant(SEL_CPU, 1'b1);
        end
        for (int i = 0; i < 400 && grants < 6; i++) step();
        chk("rr_grants", 32'(grants), 32'd6);
        dma_req = 1'b0; cpu_rearm = 1'b0;
        repeat (30) step();
        chk("rr_acks", 32'(acks), 32'd3);

        // CPU abort: nAS withdrawn before seq_done, no DSACK, no CPU re-grant.
        do_reset();
        nAS = 1'b0; nRAMSEL = 1'b0; RnW = 1'b1;
        expect_grant(SEL_CPU, 1'b0);
        hold_done = 1'b1;
        for (int i = 0; i < 20 && grants == 0; i++) step();
        nAS = 1'b1; nRAMSEL = 1'b1;
        repeat (4) step();
        hold_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("abort_dsack", 32'(DSACK), 32'd0);
        end
        dma_wr = 1'b1; dma_req = 1'b1;
        expect_grant(SEL_DMA, 1'b1);
        for (int i = 0; i < 30 && acks == 0; i++) step();
        chk("abort_next_dma", 32'(acks), 32'd1);

        // Long CPU cycle backs up refresh: pending saturates, fourth tick overflows.
        do_reset();
        nAS = 1'b0; nRAMSEL = 1'b0; RnW = 1'b1;
        expect_grant(SEL_CPU, 1'b0);
        hold_done = 1'b1; cpu_auto = 1'b1; cpu_rearm = 1'b0;
        while (cyc < 4 * RCNT - 1) step();
        chk("ovf_pre", 32'(refresh_ovf), 32'd0);
        step();
        chk("ovf_set", 32'(refresh_ovf), 32'd1);
        dma_wr = 1'b0; dma_req = 1'b1;
        expect_grant(SEL_REF, 1'b0);
        expect_grant(SEL_REF, 1'b0);
        expect_grant(SEL_REF, 1'b0);
        expect_grant(SEL_DMA, 1'b0);
        hold_done = 1'b0;
        for (int i = 0; i < 300 && acks == 0; i++) step();
        chk("ref_then_dma", 32'(acks), 32'd1);
        chk("ref_q_drained", 32'(exp_q.size()), 32'd0);
        repeat (5) step();
        chk("ovf_sticky", 32'(refresh_ovf), 32'd1);

        // Reset while the CPU holds DSACK, then the first refresh after release.
        cpu_auto = 1'b0;
        nAS = 1'b0; nRAMSEL = 1'b0; RnW = 1'b1;
        expect_grant(SEL_CPU, 1'b0);
        for (int i = 0; i < 60 && DSACK != 2'b11; i++) step();
        chk("hold_reached", 32'(DSACK), 32'd3);
        do_reset();
        expect_grant(SEL_REF, 1'b0);
        for (int i = 0; i < int'(RCNT) + 20 && grants == 0; i++) step();
        chk("first_ref_cyc", 32'(start_cyc), 32'(RCNT + 1));
        repeat (10) step();
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
